// File: rtl/m14k_bist_pkg.sv
// Shared definitions for the I-cache BIST collar: FSM states, March C- element
// table and bit positions of the status bus returned to the BIST controller.
package m14k_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } bist_state_e;

    localparam int BF_BUSY = 0;
    localparam int BF_DONE = 1;
    localparam int BF_FAIL = 2;

    typedef struct packed {
        logic dir_down;
        logic rd_exp;
        logic wr_val;
        logic has_read;
        logic has_write;
    } march_elem_t;

    // M5 is direction-agnostic; it runs upwards.
    function automatic march_elem_t march_elem(input bist_state_e st);
        case (st)
            ST_M0:   march_elem = '{dir_down: 1'b0, rd_exp: 1'b0, wr_val: 1'b0, has_read: 1'b0, has_write: 1'b1};
            ST_M1:   march_elem = '{dir_down: 1'b0, rd_exp: 1'b0, wr_val: 1'b1, has_read: 1'b1, has_write: 1'b1};
            ST_M2:   march_elem = '{dir_down: 1'b0, rd_exp: 1'b1, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b1};
            ST_M3:   march_elem = '{dir_down: 1'b1, rd_exp: 1'b0, wr_val: 1'b1, has_read: 1'b1, has_write: 1'b1};
            ST_M4:   march_elem = '{dir_down: 1'b1, rd_exp: 1'b1, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b1};
            ST_M5:   march_elem = '{dir_down: 1'b0, rd_exp: 1'b0, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b0};
            default: march_elem = '0;
        endcase
    endfunction

    function automatic bist_state_e next_elem(input bist_state_e st);
        case (st)
            ST_M0:   next_elem = ST_M1;
            ST_M1:   next_elem = ST_M2;
            ST_M2:   next_elem = ST_M3;
            ST_M3:   next_elem = ST_M4;
            ST_M4:   next_elem = ST_M5;
            default: next_elem = ST_DRAIN;
        endcase
    endfunction

endpackage

// File: rtl/m14k_bist_addr_gen.sv
// Loadable up/down address counter for March sequencing; the terminal flag marks
// the last address in the current direction.
module m14k_bist_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  dir,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  term
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (inc) begin
            addr_d = dir ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign term = dir ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/m14k_cache_bist_collar.sv
// Array-side March C- BIST responder for one I-cache RAM; functional accesses
// pass through to the RAM whenever the collar is not busy.
module m14k_cache_bist_collar
    import m14k_bist_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int BIST_TO_WIDTH   = 2,
    parameter int BIST_FROM_WIDTH = 3
) (
    input  logic                       gclk,
    input  logic                       greset_n,
    input  logic [BIST_TO_WIDTH-1:0]   bist_to,
    output logic [BIST_FROM_WIDTH-1:0] bist_from,
    output logic [ADDR_WIDTH-1:0]      bist_fail_addr,
    input  logic [ADDR_WIDTH-1:0]      func_addr,
    input  logic                       func_rd_en,
    input  logic                       func_wr_en,
    input  logic [DATA_WIDTH-1:0]      func_wdata,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic                       ram_rd_en,
    output logic                       ram_wr_en,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    input  logic [DATA_WIDTH-1:0]      ram_rdata
);

    if (BIST_TO_WIDTH != 2 || BIST_FROM_WIDTH != 3) begin : g_bad_width
        $error("m14k_cache_bist_collar: BIST bus widths must be 2 (to) and 3 (from)");
    end

    bist_state_e           state_q;
    logic                  phase_q;
    logic                  busy_q, done_q, fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic                  cmp_valid_q, cmp_exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;

    logic                  bist_en, bist_start;
    march_elem_t           elem;
    logic                  two_op, step_done, op_rd, op_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  term;
    logic                  ag_inc, ag_load;
    logic [ADDR_WIDTH-1:0] ag_load_val;

    assign bist_en    = bist_to[0];
    assign bist_start = bist_to[1];
    assign elem       = march_elem(state_q);
    assign two_op     = elem.has_read & elem.has_write;
    // In read+write elements the address only advances after the write cycle.
    assign step_done  = ~two_op | phase_q;
    assign op_rd      = elem.has_read  & (~elem.has_write | ~phase_q);
    assign op_wr      = elem.has_write & (~elem.has_read  |  phase_q);

    always_comb begin
        ag_inc      = 1'b0;
        ag_load     = 1'b0;
        ag_load_val = '0;
        if (!bist_en || ((state_q == ST_IDLE || state_q == ST_DONE) && bist_start)) begin
            ag_load = 1'b1;
        end else if (elem.has_read || elem.has_write) begin
            if (step_done && term) begin
                case (state_q)
                    ST_M2:   begin ag_load = 1'b1; ag_load_val = '1; end
                    ST_M3:   ag_inc  = 1'b1;
                    default: ag_load = 1'b1;
                endcase
            end else if (step_done) begin
                ag_inc = 1'b1;
            end
        end
    end

    m14k_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk      (gclk),
        .rst_n    (greset_n),
        .inc      (ag_inc),
        .dir      (elem.dir_down),
        .load     (ag_load),
        .load_val (ag_load_val),
        .addr     (addr),
        .term     (term)
    );

    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
        end else if (!bist_en) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
        end else begin
            cmp_valid_q <= op_rd;
            cmp_exp_q   <= elem.rd_exp;
            cmp_addr_q  <= addr;
            if (cmp_valid_q && !fail_q && (ram_rdata != {DATA_WIDTH{cmp_exp_q}})) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bist_start) begin
                        state_q     <= ST_M0;
                        phase_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    phase_q <= two_op & ~phase_q;
                    if (step_done && term) begin
                        state_q <= next_elem(state_q);
                    end
                end
            endcase
        end
    end

    assign bist_from      = {fail_q, done_q, busy_q};
    assign bist_fail_addr = fail_addr_q;

    assign ram_addr  = busy_q ? addr  : func_addr;
    assign ram_rd_en = busy_q ? op_rd : func_rd_en;
    assign ram_wr_en = busy_q ? op_wr : func_wr_en;
    assign ram_wdata = busy_q ? {DATA_WIDTH{elem.wr_val}} : func_wdata;

endmodule

// File: tb/tb_m14k_cache_bist_collar.sv
// Directed bench for the BIST collar with a 16-word RAM model that can carry a
// stuck-at or a coupling fault.
module tb_m14k_cache_bist_collar;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          gclk = 1'b0;
    logic          greset_n;
    logic [1:0]    bist_to;
    logic [2:0]    bist_from;
    logic [AW-1:0] bist_fail_addr;
    logic [AW-1:0] func_addr;
    logic          func_rd_en, func_wr_en;
    logic [DW-1:0] func_wdata;
    logic [AW-1:0] ram_addr;
    logic          ram_rd_en, ram_wr_en;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] rdata_q;
    int            fault_mode = 0;
    int            n_wr = 0, n_rd = 0;
    int            wr0, rd0;
    int            n_pass = 0, n_total = 0;

    always #5 gclk = ~gclk;

    m14k_cache_bist_collar #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIST_TO_WIDTH(2), .BIST_FROM_WIDTH(3)
    ) dut (
        .gclk           (gclk),
        .greset_n       (greset_n),
        .bist_to        (bist_to),
        .bist_from      (bist_from),
        .bist_fail_addr (bist_fail_addr),
        .func_addr      (func_addr),
        .func_rd_en     (func_rd_en),
        .func_wr_en     (func_wr_en),
        .func_wdata     (func_wdata),
        .ram_addr       (ram_addr),
        .ram_rd_en      (ram_rd_en),
        .ram_wr_en      (ram_wr_en),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    // Mode 1: bit 5 of word 3 stuck at 1. Mode 2: writing all-ones to word 9 flips word 8.
    always @(posedge gclk) begin
        if (ram_rd_en) begin
            rdata_q <= mem[ram_addr];
            n_rd++;
        end
        if (ram_wr_en) begin
            n_wr++;
            if (fault_mode == 1 && ram_addr == 4'd3) mem[ram_addr] <= ram_wdata | 32'h20;
            else                                     mem[ram_addr] <= ram_wdata;
            if (fault_mode == 2 && ram_addr == 4'd9 && ram_wdata == '1) mem[8] <= ~mem[8];
        end
    end
    assign ram_rdata = rdata_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic start_bist();
        bist_to = 2'b11;
        tick(1);
        bist_to = 2'b01;
    endtask

    task automatic func_idle();
        func_addr = '0; func_rd_en = 1'b0; func_wr_en = 1'b0; func_wdata = '0;
    endtask

    initial begin
        greset_n = 1'b0;
        bist_to  = 2'b00;
        func_idle();
        #1;
        check("reset_from", 64'(bist_from), 64'd0);
        check("reset_fail_addr", 64'(bist_fail_addr), 64'd0);
        check("reset_wr_en", 64'(ram_wr_en), 64'd0);
        tick(2);
        greset_n = 1'b1;
        tick(1);

        // Fault-free run with functional traffic that must be ignored while busy.
        wr0 = n_wr; rd0 = n_rd;
        start_bist();
        check("t1_busy_after_start", 64'(bist_from), 64'b001);
        func_addr = 4'd15; func_rd_en = 1'b1; func_wr_en = 1'b1; func_wdata = 32'hA5A5_5A5A;
        tick(5);
        check("t1_m0_mux", {ram_addr, ram_rd_en, ram_wr_en, ram_wdata},
              {4'd5, 1'b0, 1'b1, 32'h0});
        tick(155);
        check("t1_busy_at_160", 64'(bist_from), 64'b001);
        tick(1);
        check("t1_done_at_161", 64'(bist_from), 64'b010);
        check("t1_writes", 64'(n_wr - wr0), 64'd80);
        check("t1_reads", 64'(n_rd - rd0), 64'd80);
        func_idle();
        tick(3);
        check("t1_done_holds", 64'(bist_from), 64'b010);

        // Stuck-at fault on word 3, restarted from DONE.
        fault_mode = 1;
        start_bist();
        tick(160);
        check("t2_busy_at_160", 64'(bist_from[0]), 64'd1);
        tick(1);
        check("t2_from", 64'(bist_from), 64'b110);
        check("t2_fail_addr", 64'(bist_fail_addr), 64'd3);

        // Coupling fault 9 -> 8; fail address must survive bist_en dropping.
        fault_mode = 2;
        start_bist();
        check("t3_start_clears", {bist_from, bist_fail_addr}, {3'b001, 4'd0});
        tick(161);
        check("t3_from", 64'(bist_from), 64'b110);
        check("t3_fail_addr", 64'(bist_fail_addr), 64'd8);
        bist_to = 2'b00;
        tick(1);
        check("t3_en_drop_from", 64'(bist_from), 64'd0);
        check("t3_fail_addr_holds", 64'(bist_fail_addr), 64'd8);
        fault_mode = 0;

        // Abort by dropping bist_en mid-run.
        start_bist();
        tick(40);
        check("t4_busy_mid", 64'(bist_from), 64'b001);
        bist_to = 2'b00;
        tick(1);
        check("t4_abort_from", 64'(bist_from), 64'd0);
        func_addr = 4'd7; func_rd_en = 1'b1;
        #1;
        check("t4_func_restored", {ram_addr, ram_rd_en, ram_wr_en}, {4'd7, 1'b1, 1'b0});
        func_idle();
        tick(1);

        // Repeated start while busy is ignored.
        bist_to = 2'b01;
        tick(1);
        start_bist();
        tick(20);
        bist_to = 2'b11;
        tick(1);
        bist_to = 2'b01;
        tick(139);
        check("t5_busy_at_160", 64'(bist_from), 64'b001);
        tick(1);
        check("t5_done_at_161", 64'(bist_from), 64'b010);

        // Asynchronous reset in the middle of a failing run.
        fault_mode = 1;
        start_bist();
        tick(49);
        check("t5_fail_before_reset", {bist_from, bist_fail_addr}, {3'b101, 4'd3});
        greset_n = 1'b0;
        #1;
        check("t5_reset_from", 64'(bist_from), 64'd0);
        check("t5_reset_fail_addr", 64'(bist_fail_addr), 64'd0);
        check("t5_reset_wr_en", 64'(ram_wr_en), 64'd0);
        tick(1);
        greset_n = 1'b1;
        fault_mode = 0;
        bist_to = 2'b00;
        tick(1);

        // Functional pass-through with random traffic.
        for (int i = 0; i < 200; i++) begin
            func_addr  = 4'($urandom_range(0, 15));
            func_rd_en = 1'($urandom_range(0, 1));
            func_wr_en = 1'($urandom_range(0, 1));
            func_wdata = $urandom;
            #1;
            check("t6_passthrough", {ram_addr, ram_rd_en, ram_wr_en, ram_wdata, bist_from},
                  {func_addr, func_rd_en, func_wr_en, func_wdata, 3'b000});
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
